// File: rtl/bcd_down_timer.sv
// ============================================================================
// Module   : bcd_down_timer
// Purpose  : Loadable multi-digit BCD countdown timer with IDLE/RUN/PAUSED/DONE
//            control. Optional macro BCD_DOWN_TIMER_AUTO_RELOAD_EN reloads the
//            count at the terminal tick instead of stopping.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick_en,
    output logic [4*DIGITS-1:0]   cnt,
    output logic                  zero,
    output logic                  busy,
    output logic                  done
);

    localparam int c_CNT_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        c_IDLE   = 2'd0,
        c_RUN    = 2'd1,
        c_PAUSED = 2'd2,
        c_DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [c_CNT_W-1:0]   reload_q, reload_d;
    logic                 done_q, done_d;

    // Saturate each digit to 9 so the counter never holds a non-BCD code.
    function automatic logic [c_CNT_W-1:0] bcd_clamp(input logic [c_CNT_W-1:0] v);
        logic [c_CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    function automatic logic [c_CNT_W-1:0] bcd_dec(input logic [c_CNT_W-1:0] v);
        logic [c_CNT_W-1:0] r;
        logic               borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;

        if (load) begin
            cnt_d    = bcd_clamp(load_val);
            reload_d = bcd_clamp(load_val);
            state_d  = c_IDLE;
        end else begin
            case (state_q)
                c_IDLE: begin
                    if (!pause && start) begin
                        if (cnt_q != '0) begin
                            state_d = c_RUN;
                        end else begin
                            state_d = c_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    if (pause) begin
                        state_d = c_PAUSED;
                    end else if (tick_en) begin
                        if (cnt_q == c_CNT_W'(1)) begin
                            done_d = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
                            // reload is never 0 here in practice; guard keeps RUN nonzero
                            cnt_d   = reload_q;
                            state_d = (reload_q != '0) ? c_RUN : c_DONE;
`else
                            cnt_d   = '0;
                            state_d = c_DONE;
`endif
                        end else begin
                            cnt_d = bcd_dec(cnt_q);
                        end
                    end
                end
                c_PAUSED: begin
                    if (!pause && start) begin
                        state_d = c_RUN;
                    end
                end
                default: begin
                    state_d = c_DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= c_IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);
    assign busy = (state_q == c_RUN) || (state_q == c_PAUSED);
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_down_timer.sv
// ============================================================================
// Module   : tb_bcd_down_timer
// Purpose  : Table-driven and directed checks for bcd_down_timer (DIGITS=4).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bcd_down_timer;

    logic        clk;
    logic        rstn;
    logic        load;
    logic [15:0] load_val;
    logic        start;
    logic        pause;
    logic        tick_en;
    logic [15:0] cnt;
    logic        zero;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        st;
        logic        pa;
        logic        tk;
        logic [15:0] e_cnt;
        logic        e_zero;
        logic        e_busy;
        logic        e_done;
    } vec_t;

    vec_t vecs[$];

    bcd_down_timer #(.DIGITS(4)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .tick_en  (tick_en),
        .cnt      (cnt),
        .zero     (zero),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic ld, input logic [15:0] lv, input logic st,
                       input logic pa, input logic tk, input logic [15:0] ec,
                       input logic ez, input logic eb, input logic ed);
        vec_t v;
        v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.tk = tk;
        v.e_cnt = ec; v.e_zero = ez; v.e_busy = eb; v.e_done = ed;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] ec,
                         input logic ez, input logic eb, input logic ed);
        checks++;
        if (cnt !== ec || zero !== ez || busy !== eb || done !== ed) begin
            errors++;
            $display("FAIL %s: got cnt=%h zero=%b busy=%b done=%b, expected cnt=%h zero=%b busy=%b done=%b",
                     name, cnt, zero, busy, done, ec, ez, eb, ed);
        end
    endtask

    // Drive inputs at the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input logic ld, input logic [15:0] lv, input logic st,
                         input logic pa, input logic tk);
        @(negedge clk);
        load = ld; load_val = lv; start = st; pause = pa; tick_en = tk;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int          m;
        m = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    initial begin
        rstn = 1'b0; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0; tick_en = 1'b0;

        //   ld  load_val  st pa tk   cnt     z  b  d
        add(1, 16'h1000, 0, 0, 0, 16'h1000, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h1000, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0999, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0998, 0, 1, 0);
        add(1, 16'h00AF, 0, 0, 0, 16'h0099, 0, 0, 0);
        add(1, 16'h0005, 0, 0, 0, 16'h0005, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 1, 16'h0005, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0004, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0003, 0, 1, 0);
        add(0, 16'h0000, 0, 1, 1, 16'h0003, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0003, 0, 1, 0);
        add(0, 16'h0000, 1, 0, 1, 16'h0003, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0002, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0001, 0, 1, 0);
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        add(0, 16'h0000, 0, 0, 1, 16'h0005, 0, 1, 1);
        add(0, 16'h0000, 0, 0, 1, 16'h0004, 0, 1, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0004, 0, 1, 0);
`else
        add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 1);
        add(0, 16'h0000, 0, 0, 1, 16'h0000, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 0);
`endif
        add(1, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0000, 1, 0, 1);
        add(0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0);
        add(1, 16'h0010, 1, 1, 1, 16'h0010, 0, 0, 0);
        add(0, 16'h0000, 0, 1, 0, 16'h0010, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'h0010, 0, 1, 0);
        add(0, 16'h0000, 0, 0, 1, 16'h0009, 0, 1, 0);
        add(1, 16'h9A3F, 0, 0, 0, 16'h9939, 0, 0, 0);

        // Reset state
        #12;
        check("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].ld, vecs[i].lv, vecs[i].st, vecs[i].pa, vecs[i].tk);
            check($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_zero,
                  vecs[i].e_busy, vecs[i].e_done);
        end

        // Full countdown from 12 with decimal borrow 10 -> 9
        apply(1, 16'h0012, 0, 0, 0);
        apply(0, 16'h0000, 1, 0, 0);
        for (int n = 11; n >= 0; n--) begin
            apply(0, 16'h0000, 0, 0, 1);
`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
            if (n == 0) check("cd12_end", 16'h0012, 1'b0, 1'b1, 1'b1);
            else        check($sformatf("cd12_%0d", n), to_bcd(n), 1'b0, 1'b1, 1'b0);
`else
            check($sformatf("cd12_%0d", n), to_bcd(n), n == 0, n != 0, n == 0);
`endif
        end

        // Asynchronous reset mid-run
        apply(1, 16'h0050, 0, 0, 0);
        apply(0, 16'h0000, 1, 0, 0);
        for (int i = 0; i < 20; i++) apply(0, 16'h0000, 0, 0, 1);
        check("run_to_30", 16'h0030, 1'b0, 1'b1, 1'b0);
        #2 rstn = 1'b0;
        #1 check("async_rst", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_hold", 16'h0000, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rstn = 1'b1; tick_en = 1'b0;
        @(posedge clk); #1;
        check("rst_release", 16'h0000, 1'b1, 1'b0, 1'b0);

`ifdef BCD_DOWN_TIMER_AUTO_RELOAD_EN
        apply(1, 16'h0003, 0, 0, 0);
        apply(0, 16'h0000, 1, 0, 0);
        for (int k = 0; k < 6; k++) begin
            apply(0, 16'h0000, 0, 0, 1);
            check($sformatf("ar3_%0d", k), to_bcd(2 - (k % 3) + ((k % 3) == 2 ? 3 : 0)),
                  1'b0, 1'b1, (k % 3) == 2);
        end
        apply(1, 16'h00AF, 0, 0, 0);
        apply(0, 16'h0000, 1, 0, 0);
        for (int k = 0; k < 99; k++) apply(0, 16'h0000, 0, 0, 1);
        check("ar_clamped_reload", 16'h0099, 1'b0, 1'b1, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
